bsg_cache_tb_tracker: RTL and testbench

BSG_CACHE_TB_TRACKER -- requirements
Module: bsg_cache_tb_tracker

---
 rtl/bsg_cache_tb_tracker_pkg.sv | 29 ++
 rtl/bsg_cache_tb_tracker_ts_fifo.sv | 66 ++++++
 rtl/bsg_cache_tb_tracker.sv | 218 +++++++++++++++++++++
 tb/tb_bsg_cache_tb_tracker.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_cache_tb_tracker_pkg.sv
// Shared types for the cache testbench traffic tracker.
// Optional latency tracking is compiled in with BSG_CACHE_TB_LATENCY_EN.
package bsg_cache_tb_tracker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_UNDERFLOW = 2'd0,
        ERR_OVERFLOW  = 2'd1,
        ERR_POST_DONE = 2'd2,
        ERR_TIMEOUT   = 2'd3
    } err_cause_e;

    localparam int unsigned num_causes_lp = 4;

    typedef logic [31:0] cnt32_t;

    // Index width that never collapses to zero bits
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_cache_tb_tracker_ts_fifo.sv
// In-order timestamp FIFO for one channel; head is combinational and
// bypasses the incoming word when the FIFO is empty.
// Instantiated only when BSG_CACHE_TB_LATENCY_EN is defined.
module bsg_cache_tb_ts_fifo #(
    parameter int unsigned depth_p = 16,
    parameter int unsigned width_p = 32,
    localparam int unsigned aw_lp = (depth_p > 1) ? $clog2(depth_p) : 1,
    localparam int unsigned cw_lp = $clog2(depth_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic [width_p-1:0] head_c_o
);

    logic [width_p-1:0] mem_q [depth_p];
    logic [aw_lp-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cw_lp-1:0]   cnt_q, cnt_d;
    logic               empty, full, bypass, wr, rd;

    function automatic logic [aw_lp-1:0] ptr_inc(input logic [aw_lp-1:0] p);
        return (p == aw_lp'(depth_p - 1)) ? '0 : p + aw_lp'(1);
    endfunction

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == cw_lp'(depth_p));
    assign bypass   = empty & push_i & pop_i;
    assign wr       = push_i & ~bypass & (~full | pop_i);
    assign rd       = pop_i & ~empty;
    assign head_c_o = empty ? data_i : mem_q[rptr_q];

    // Pointer and occupancy update
    always_comb begin
        wptr_d = wr ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = rd ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        if (wr && !rd) begin
            cnt_d = cnt_q + cw_lp'(1);
        end else if (rd && !wr) begin
            cnt_d = cnt_q - cw_lp'(1);
        end
    end

    // Control state
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage, no reset needed
    always_ff @(posedge clk_i) begin
        if (wr) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bsg_cache_tb_tracker.sv
// Tracks cache request/response traffic per channel, detects protocol
// violations and stalls, and declares completion after a quiet drain.
// Define BSG_CACHE_TB_LATENCY_EN to add per-channel min/max latency.
module bsg_cache_tb_tracker
    import bsg_cache_tb_tracker_pkg::*;
#(
    parameter int unsigned num_chan_p        = 1,
    parameter int unsigned max_outstanding_p = 16,
    parameter int unsigned timeout_p         = 4096,
    parameter int unsigned drain_p           = 8,
    localparam int unsigned ow_lp = $clog2(max_outstanding_p + 1),
    localparam int unsigned cw_lp = clog2_min1(num_chan_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [num_chan_p-1:0]       req_v_i,
    input  logic [num_chan_p-1:0]       req_ready_i,
    input  logic [num_chan_p-1:0]       resp_v_i,
    input  logic [num_chan_p-1:0]       resp_yumi_i,
    input  logic [num_chan_p-1:0]       trace_done_i,
    output logic [num_chan_p*ow_lp-1:0] outstanding_o,
    output logic [31:0]                 sent_o,
    output logic [31:0]                 recv_o,
    output logic                        done_o,
    output logic                        timeout_o,
    output logic                        error_o,
    output logic [cw_lp-1:0]            err_chan_o
`ifdef BSG_CACHE_TB_LATENCY_EN
    ,
    output logic [num_chan_p*32-1:0]    lat_min_o,
    output logic [num_chan_p*32-1:0]    lat_max_o
`endif
);

    localparam int unsigned tw_lp = $clog2(timeout_p + 1);
    localparam int unsigned dw_lp = $clog2(drain_p + 1);

    logic [num_chan_p-1:0]            req_fire, resp_fire, uf, of, err_vec;
    logic                             any_req, any_resp, any_fire, all_zero_q;
    logic [num_chan_p-1:0][ow_lp-1:0] out_q, out_d;
    cnt32_t                           sent_q, sent_d, recv_q, recv_d;
    logic [tw_lp-1:0]                 wd_q, wd_d;
    logic [dw_lp-1:0]                 drain_q, drain_d;
    state_e                           state_q, state_d;
    logic                             done_q, done_d, error_q, error_d, timeout_q, timeout_d;
    logic [cw_lp-1:0]                 err_chan_q, err_chan_d;
    logic [num_causes_lp-1:0]         cause_c;

    assign req_fire   = req_v_i & req_ready_i;
    assign resp_fire  = resp_v_i & resp_yumi_i;
    assign any_req    = |req_fire;
    assign any_resp   = |resp_fire;
    assign any_fire   = any_req | any_resp;
    assign all_zero_q = (out_q == '0);

    // Per-channel accounting, totals, watchdog and error causes
    always_comb begin
        out_d   = out_q;
        sent_d  = sent_q;
        recv_d  = recv_q;
        uf      = '0;
        of      = '0;
        err_vec = '0;
        wd_d    = '0;
        cause_c = '0;
        for (int i = 0; i < num_chan_p; i++) begin
            sent_d = sent_d + cnt32_t'(req_fire[i]);
            recv_d = recv_d + cnt32_t'(resp_fire[i]);
            if (req_fire[i] && !resp_fire[i]) begin
                if (out_q[i] == ow_lp'(max_outstanding_p)) of[i] = 1'b1;
                else out_d[i] = out_q[i] + ow_lp'(1);
            end else if (!req_fire[i] && resp_fire[i]) begin
                if (out_q[i] == '0) uf[i] = 1'b1;
                else out_d[i] = out_q[i] - ow_lp'(1);
            end
        end
        if (state_q == ST_RUN && !all_zero_q && !any_resp) begin
            wd_d = (wd_q == tw_lp'(timeout_p)) ? wd_q : wd_q + tw_lp'(1);
        end
        cause_c[ERR_UNDERFLOW] = |uf;
        cause_c[ERR_OVERFLOW]  = |of;
        cause_c[ERR_POST_DONE] = (state_q == ST_DONE) && any_fire;
        cause_c[ERR_TIMEOUT]   = (wd_d == tw_lp'(timeout_p));
        err_vec = uf | of;
        if (cause_c[ERR_POST_DONE]) err_vec |= req_fire | resp_fire;
        if (cause_c[ERR_TIMEOUT]) begin
            for (int i = 0; i < num_chan_p; i++) begin
                err_vec[i] = err_vec[i] | (out_q[i] != '0);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Next state and drain counter
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) state_d = ST_RUN;
            end
            ST_RUN: begin
                drain_d = '0;
                if ((&trace_done_i) && all_zero_q && !any_fire) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (any_fire) begin
                    state_d = ST_RUN;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + dw_lp'(1);
                    if (drain_d == dw_lp'(drain_p)) state_d = ST_DONE;
                end
            end
            default: ;
        endcase
        if (|cause_c) state_d = ST_ERROR;
    end

    // Status outputs; first error channel is captured once
    always_comb begin
        done_d     = (state_d == ST_DONE);
        error_d    = error_q | cause_c[ERR_UNDERFLOW] | cause_c[ERR_OVERFLOW] | cause_c[ERR_POST_DONE];
        timeout_d  = timeout_q | cause_c[ERR_TIMEOUT];
        err_chan_d = err_chan_q;
        if (!error_q && !timeout_q) begin
            for (int i = int'(num_chan_p) - 1; i >= 0; i--) begin
                if (err_vec[i]) err_chan_d = cw_lp'(i);
            end
        end
    end

    // Datapath and status registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            out_q      <= '0;
            sent_q     <= '0;
            recv_q     <= '0;
            wd_q       <= '0;
            drain_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            timeout_q  <= 1'b0;
            err_chan_q <= '0;
        end else begin
            out_q      <= out_d;
            sent_q     <= sent_d;
            recv_q     <= recv_d;
            wd_q       <= wd_d;
            drain_q    <= drain_d;
            done_q     <= done_d;
            error_q    <= error_d;
            timeout_q  <= timeout_d;
            err_chan_q <= err_chan_d;
        end
    end

    assign outstanding_o = out_q;
    assign sent_o        = sent_q;
    assign recv_o        = recv_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign timeout_o     = timeout_q;
    assign err_chan_o    = err_chan_q;

`ifdef BSG_CACHE_TB_LATENCY_EN
    cnt32_t                        ts_q;
    logic [num_chan_p-1:0][31:0]   head_c, lat_min_q, lat_min_d, lat_max_q, lat_max_d;

    for (genvar g = 0; g < num_chan_p; g++) begin : g_fifo
        bsg_cache_tb_ts_fifo #(
            .depth_p(max_outstanding_p),
            .width_p(32)
        ) u_fifo (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .push_i   (req_fire[g] & ~of[g]),
            .data_i   (ts_q),
            .pop_i    (resp_fire[g] & ~uf[g]),
            .head_c_o (head_c[g])
        );
    end

    // Fold completed-request latency into per-channel min/max
    always_comb begin
        lat_min_d = lat_min_q;
        lat_max_d = lat_max_q;
        for (int i = 0; i < num_chan_p; i++) begin
            if (resp_fire[i] && !uf[i]) begin
                if ((ts_q - head_c[i]) < lat_min_q[i]) lat_min_d[i] = ts_q - head_c[i];
                if ((ts_q - head_c[i]) > lat_max_q[i]) lat_max_d[i] = ts_q - head_c[i];
            end
        end
    end

    // Free-running timestamp and latency registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ts_q      <= '0;
            lat_min_q <= '1;
            lat_max_q <= '0;
        end else begin
            ts_q      <= ts_q + cnt32_t'(1);
            lat_min_q <= lat_min_d;
            lat_max_q <= lat_max_d;
        end
    end

    assign lat_min_o = lat_min_q;
    assign lat_max_o = lat_max_q;
`endif

endmodule

// File: tb/tb_bsg_cache_tb_tracker.sv
// Self-checking bench for bsg_cache_tb_tracker (two channels, small limits).
module tb_bsg_cache_tb_tracker;

    localparam int unsigned NC = 2;
    localparam int unsigned MO = 4;
    localparam int unsigned TO = 100;
    localparam int unsigned DR = 8;
    localparam int unsigned OW = $clog2(MO + 1);
    localparam int unsigned CW = 1;

    logic              clk_i = 1'b0;
    logic              reset_n_i = 1'b0;
    logic [NC-1:0]     req_v_i, req_ready_i, resp_v_i, resp_yumi_i, trace_done_i;
    logic [NC*OW-1:0]  outstanding_o;
    logic [31:0]       sent_o, recv_o;
    logic              done_o, timeout_o, error_o;
    logic [CW-1:0]     err_chan_o;
`ifdef BSG_CACHE_TB_LATENCY_EN
    logic [NC*32-1:0]  lat_min_o, lat_max_o;
`endif

    bsg_cache_tb_tracker #(
        .num_chan_p       (NC),
        .max_outstanding_p(MO),
        .timeout_p        (TO),
        .drain_p          (DR)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .req_v_i      (req_v_i),
        .req_ready_i  (req_ready_i),
        .resp_v_i     (resp_v_i),
        .resp_yumi_i  (resp_yumi_i),
        .trace_done_i (trace_done_i),
        .outstanding_o(outstanding_o),
        .sent_o       (sent_o),
        .recv_o       (recv_o),
        .done_o       (done_o),
        .timeout_o    (timeout_o),
        .error_o      (error_o),
        .err_chan_o   (err_chan_o)
`ifdef BSG_CACHE_TB_LATENCY_EN
        ,
        .lat_min_o    (lat_min_o),
        .lat_max_o    (lat_max_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]    rv, rr, sv, sy, td;
        logic [OW-1:0] o0, o1;
        logic [31:0]   sent, recv;
        logic          err;
    } vec_t;

    typedef struct {
        logic [OW-1:0] o0, o1;
        logic [31:0]   sent, recv;
        logic          err;
    } exp_t;

    vec_t vecs [9];
    exp_t sb [$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;
    logic seen_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [1:0] rv, input logic [1:0] sv, input logic [1:0] td);
        req_v_i      = rv;
        req_ready_i  = 2'b11;
        resp_v_i     = sv;
        resp_yumi_i  = 2'b11;
        trace_done_i = td;
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        drive(2'b00, 2'b00, 2'b00);
        tick();
        tick();
        reset_n_i = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got expired, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        drive(2'b00, 2'b00, 2'b00);
        do_reset();

        // Reset state
        check("rst.outstanding", 32'(outstanding_o), 32'd0);
        check("rst.sent",        sent_o,              32'd0);
        check("rst.recv",        recv_o,              32'd0);
        check("rst.flags",       32'({done_o, timeout_o, error_o, err_chan_o}), 32'd0);

        // rv rr sv sy td | out0 out1 sent recv err
        vecs[0] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 3'd1, 3'd1, 32'd2, 32'd0, 1'b0};
        vecs[1] = '{2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 3'd2, 3'd1, 32'd3, 32'd0, 1'b0};
        vecs[2] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'd2, 3'd1, 32'd3, 32'd0, 1'b0};
        vecs[3] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 3'd3, 3'd1, 32'd4, 32'd0, 1'b0};
        vecs[4] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 3'd3, 3'd1, 32'd5, 32'd1, 1'b0};
        vecs[5] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 3'd2, 3'd0, 32'd5, 32'd3, 1'b0};
        vecs[6] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 3'd1, 3'd1, 32'd6, 32'd4, 1'b0};
        vecs[7] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 3'd0, 3'd0, 32'd6, 32'd6, 1'b0};
        vecs[8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 3'd0, 3'd0, 32'd6, 32'd6, 1'b0};

        for (int i = 0; i < 9; i++) begin
            req_v_i      = vecs[i].rv;
            req_ready_i  = vecs[i].rr;
            resp_v_i     = vecs[i].sv;
            resp_yumi_i  = vecs[i].sy;
            trace_done_i = vecs[i].td;
            sb.push_back('{o0: vecs[i].o0, o1: vecs[i].o1, sent: vecs[i].sent,
                           recv: vecs[i].recv, err: vecs[i].err});
            tick();
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL vec%0d.scoreboard: got empty, expected entry", i);
            end else begin
                e = sb.pop_front();
                check($sformatf("vec%0d.out0", i),  32'(outstanding_o[OW-1:0]),    32'(e.o0));
                check($sformatf("vec%0d.out1", i),  32'(outstanding_o[2*OW-1:OW]), 32'(e.o1));
                check($sformatf("vec%0d.sent", i),  sent_o,                        e.sent);
                check($sformatf("vec%0d.recv", i),  recv_o,                        e.recv);
                check($sformatf("vec%0d.error", i), 32'(error_o),                  32'(e.err));
            end
        end

        // Full trace with drain: 5 ch0 + 3 ch1 requests, done drain+1 cycles after last response
        do_reset();
        drive(2'b11, 2'b00, 2'b11); tick();
        drive(2'b11, 2'b00, 2'b11); tick();
        drive(2'b11, 2'b00, 2'b11); tick();
        check("trace.out_peak", 32'(outstanding_o), 32'({3'd3, 3'd3}));
        drive(2'b01, 2'b11, 2'b11); tick();
        drive(2'b01, 2'b01, 2'b11); tick();
        check("trace.out_mid", 32'(outstanding_o), 32'({3'd2, 3'd3}));
        drive(2'b00, 2'b11, 2'b11); tick();
        drive(2'b00, 2'b11, 2'b11); tick();
        drive(2'b00, 2'b01, 2'b11); tick();
        drive(2'b00, 2'b00, 2'b11);
        for (int k = 1; k <= int'(DR) + 1; k++) begin
            tick();
            if (k == int'(DR))     check("trace.done_early", 32'(done_o), 32'd0);
            if (k == int'(DR) + 1) check("trace.done",       32'(done_o), 32'd1);
        end
        check("trace.sent", sent_o, 32'd8);
        check("trace.recv", recv_o, 32'd8);
        check("trace.out_zero", 32'(outstanding_o), 32'd0);
        drive(2'b01, 2'b00, 2'b11); tick();
        check("post_done.error", 32'(error_o), 32'd1);
        check("post_done.done",  32'(done_o),  32'd0);

        // Underflow on ch1, later error does not overwrite, done never asserts
        do_reset();
        drive(2'b00, 2'b10, 2'b00); tick();
        check("uf1.error",    32'(error_o),    32'd1);
        check("uf1.err_chan", 32'(err_chan_o), 32'd1);
        check("uf1.out",      32'(outstanding_o), 32'd0);
        drive(2'b00, 2'b01, 2'b00); tick();
        check("uf1.err_chan_held", 32'(err_chan_o), 32'd1);
        seen_done = 1'b0;
        drive(2'b00, 2'b00, 2'b11);
        for (int k = 0; k < 20; k++) begin
            tick();
            seen_done = seen_done | done_o;
        end
        check("uf1.never_done", 32'(seen_done), 32'd0);

        // Simultaneous underflow on both channels picks lowest index
        do_reset();
        drive(2'b00, 2'b11, 2'b00); tick();
        check("uf_both.err_chan", 32'(err_chan_o), 32'd0);
        check("uf_both.error",    32'(error_o),    32'd1);

        // Watchdog: one ch1 request, no response
        do_reset();
        drive(2'b10, 2'b00, 2'b00); tick();
        drive(2'b00, 2'b00, 2'b00);
        for (int k = 1; k <= int'(TO); k++) begin
            tick();
            if (k == int'(TO) - 1) check("wd.before", 32'(timeout_o), 32'd0);
            if (k == int'(TO))     check("wd.expire", 32'(timeout_o), 32'd1);
        end
        check("wd.err_chan", 32'(err_chan_o), 32'd1);
        check("wd.error",    32'(error_o),    32'd0);
        check("wd.done",     32'(done_o),     32'd0);

        // Overflow at max_outstanding
        do_reset();
        for (int k = 0; k < int'(MO); k++) begin
            drive(2'b01, 2'b00, 2'b00); tick();
        end
        check("of.full_out",   32'(outstanding_o[OW-1:0]), 32'd4);
        check("of.full_error", 32'(error_o),               32'd0);
        drive(2'b01, 2'b01, 2'b00); tick();
        check("of.both_out",   32'(outstanding_o[OW-1:0]), 32'd4);
        check("of.both_error", 32'(error_o),               32'd0);
        drive(2'b01, 2'b00, 2'b00); tick();
        check("of.error",      32'(error_o),               32'd1);
        check("of.out",        32'(outstanding_o[OW-1:0]), 32'd4);
        check("of.err_chan",   32'(err_chan_o),            32'd0);

        // Asynchronous reset mid-traffic
        do_reset();
        drive(2'b01, 2'b00, 2'b00); tick();
        drive(2'b01, 2'b00, 2'b00); tick();
        check("arst.pre_out", 32'(outstanding_o[OW-1:0]), 32'd2);
        drive(2'b00, 2'b00, 2'b00);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("arst.out",   32'(outstanding_o), 32'd0);
        check("arst.sent",  sent_o,             32'd0);
        check("arst.recv",  recv_o,             32'd0);
        check("arst.flags", 32'({done_o, timeout_o, error_o, err_chan_o}), 32'd0);
        tick();
        reset_n_i = 1'b1;
        drive(2'b01, 2'b00, 2'b00); tick();
        check("arst.restart_out",  32'(outstanding_o[OW-1:0]), 32'd1);
        check("arst.restart_sent", sent_o,                     32'd1);

`ifdef BSG_CACHE_TB_LATENCY_EN
        // Fixed 7-cycle response latency on ch0
        do_reset();
        drive(2'b01, 2'b00, 2'b00); tick();
        drive(2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 6; k++) tick();
        drive(2'b00, 2'b01, 2'b00); tick();
        drive(2'b00, 2'b00, 2'b00);
        check("lat.min0", lat_min_o[31:0],  32'd7);
        check("lat.max0", lat_max_o[31:0],  32'd7);
        check("lat.min1", lat_min_o[63:32], 32'hffff_ffff);
        check("lat.max1", lat_max_o[63:32], 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
